// File: rtl/fp_result_queue_if.sv
// Bundle between the fpcif converter, the writeback consumer and the CSR
// block on one side, and the result queue on the other.
interface fp_result_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          fp_run;
  logic          fp_stall;
  logic [31:0]   fp_z;
  logic [4:0]    fp_flags;
  logic          q_full;
  logic [CW-1:0] q_count;
  logic          rd_valid;
  logic [31:0]   rd_z;
  logic [4:0]    rd_flags;
  logic          rd_ack;
  logic          csr_we;
  logic [9:0]    csr_wdata;
  logic [10:0]   csr_rdata;
  logic          irq;

  modport slave (
    input  fp_run, fp_stall, fp_z, fp_flags, rd_ack, csr_we, csr_wdata,
    output q_full, q_count, rd_valid, rd_z, rd_flags, csr_rdata, irq
  );

  modport master (
    output fp_run, fp_stall, fp_z, fp_flags, rd_ack, csr_we, csr_wdata,
    input  q_full, q_count, rd_valid, rd_z, rd_flags, csr_rdata, irq
  );
endinterface

// File: rtl/fp_result_queue.sv
// First-word-fall-through result FIFO behind the int-to-float converter, with
// sticky IEEE exception flags, an overflow flag and a level interrupt.
module fp_result_queue #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_result_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 37;

  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW-1:0] wr_ptr_next, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          full_reg, valid_reg;
  logic [31:0]   head_z_reg;
  logic [4:0]    head_flags_reg;
  logic [4:0]    sticky_reg, sticky_next;
  logic [4:0]    mask_reg, mask_next;
  logic          ovf_reg, ovf_next;
  logic          irq_reg, irq_next;

  logic          push_req, pop, push_ok, drop;
  logic [EW-1:0] push_entry, head_src;
  logic [4:0]    sticky_base;
  logic [4:0]    enabled;

  assign push_req   = bus.fp_run & ~bus.fp_stall;
  assign pop        = bus.rd_ack & valid_reg;
  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign push_ok    = push_req & (~full_reg | pop);
  assign drop       = push_req & full_reg & ~pop;
  assign push_entry = {bus.fp_z, bus.fp_flags};

  assign wr_ptr_next = push_ok ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
  assign rd_ptr_next = pop     ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
  assign count_next  = count_reg + CW'(push_ok) - CW'(pop);

  // The new head is the entry being written only when the write slot is
  // exactly where the read pointer lands (queue was empty, or held one
  // entry that is popped now).
  assign head_src = (push_ok && (wr_ptr_reg == rd_ptr_next)) ? push_entry
                                                             : mem[rd_ptr_next];

  assign sticky_base = bus.csr_we ? bus.csr_wdata[4:0] : sticky_reg;
  assign mask_next   = bus.csr_we ? bus.csr_wdata[9:5] : mask_reg;
  // An overflow in the same cycle as a CSR clear must survive.
  assign ovf_next    = drop | (ovf_reg & ~bus.csr_we);

  for (genvar gi = 0; gi < 5; gi++) begin : g_flag
    assign sticky_next[gi] = sticky_base[gi] | (push_ok & bus.fp_flags[gi]);
    assign enabled[gi]     = sticky_next[gi] & mask_next[gi];
  end

  assign irq_next = (|enabled) | ovf_next;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      full_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      head_z_reg     <= '0;
      head_flags_reg <= '0;
      sticky_reg     <= '0;
      mask_reg       <= '0;
      ovf_reg        <= 1'b0;
      irq_reg        <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      full_reg   <= (count_next == CW'(DEPTH));
      valid_reg  <= (count_next != '0);
      // Head output holds its last value once the queue drains.
      if (count_next != '0) begin
        head_z_reg     <= head_src[EW-1:5];
        head_flags_reg <= head_src[4:0];
      end
      sticky_reg <= sticky_next;
      mask_reg   <= mask_next;
      ovf_reg    <= ovf_next;
      irq_reg    <= irq_next;
    end
  end

  assign bus.q_full    = full_reg;
  assign bus.q_count   = count_reg;
  assign bus.rd_valid  = valid_reg;
  assign bus.rd_z      = head_z_reg;
  assign bus.rd_flags  = head_flags_reg;
  assign bus.csr_rdata = {ovf_reg, mask_reg, sticky_reg};
  assign bus.irq       = irq_reg;
endmodule

// File: tb/tb_fp_result_queue.sv
// Scoreboard bench for fp_result_queue: a reference queue plus sticky/mask/ovf
// model is advanced on every cycle and all outputs are compared after the edge.
module tb_fp_result_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fp_result_queue_if #(.DEPTH(DEPTH)) bus ();

  fp_result_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [36:0] sb [$];
  logic [36:0] m_last;
  logic [4:0]  m_sticky, m_mask;
  logic        m_ovf, m_irq;
  int          n_cmp = 0;
  int          n_err = 0;
  int          txn = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    m_last   = '0;
    m_sticky = '0;
    m_mask   = '0;
    m_ovf    = 1'b0;
    m_irq    = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [36:0] head;
    head = (sb.size() != 0) ? sb[0] : m_last;
    check_val({tag, ".count"}, 64'(bus.q_count), 64'(sb.size()));
    check_val({tag, ".full"},  64'(bus.q_full),  64'(sb.size() == DEPTH));
    check_val({tag, ".valid"}, 64'(bus.rd_valid), 64'(sb.size() != 0));
    check_val({tag, ".rd_z"},  64'(bus.rd_z),    64'(head[36:5]));
    check_val({tag, ".rd_fl"}, 64'(bus.rd_flags), 64'(head[4:0]));
    check_val({tag, ".csr"},   64'(bus.csr_rdata), 64'({m_ovf, m_mask, m_sticky}));
    check_val({tag, ".irq"},   64'(bus.irq),     64'(m_irq));
  endtask

  task automatic cycle(input string tag, input bit run, input bit stall,
                       input logic [31:0] z, input logic [4:0] fl,
                       input bit ack, input bit we, input logic [9:0] wd);
    bit pop, accepted, dropped;
    logic [4:0] s;
    bus.fp_run    = run;
    bus.fp_stall  = stall;
    bus.fp_z      = z;
    bus.fp_flags  = fl;
    bus.rd_ack    = ack;
    bus.csr_we    = we;
    bus.csr_wdata = wd;
    pop      = ack && (sb.size() != 0);
    accepted = run && !stall && ((sb.size() < DEPTH) || pop);
    dropped  = run && !stall && (sb.size() == DEPTH) && !pop;
    if (pop) void'(sb.pop_front());
    if (accepted) sb.push_back({z, fl});
    s = we ? wd[4:0] : m_sticky;
    if (accepted) s = s | fl;
    m_sticky = s;
    if (we) m_mask = wd[9:5];
    m_ovf = dropped ? 1'b1 : (we ? 1'b0 : m_ovf);
    m_irq = (|(m_sticky & m_mask)) | m_ovf;
    step();
    if (sb.size() != 0) m_last = sb[0];
    txn++;
    $display("txn %0d %s run=%0b stall=%0b z=%08h fl=%02h ack=%0b we=%0b wd=%03h -> count=%0d irq=%0b",
             txn, tag, run, stall, z, fl, ack, we, wd, bus.q_count, bus.irq);
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 32'h0, 5'h0, 0, 0, 10'h0);
  endtask

  task automatic push(input string tag, input logic [31:0] z, input logic [4:0] fl);
    cycle(tag, 1, 0, z, fl, 0, 0, 10'h0);
  endtask

  task automatic ack(input string tag);
    cycle(tag, 0, 0, 32'h0, 5'h0, 1, 0, 10'h0);
  endtask

  initial begin
    bus.fp_run = 0; bus.fp_stall = 0; bus.fp_z = '0; bus.fp_flags = '0;
    bus.rd_ack = 0; bus.csr_we = 0; bus.csr_wdata = '0;
    model_reset();
    step();
    step();
    check_outputs("reset");
    rst_n = 1'b1;

    // In-order FWFT delivery
    push("p1", 32'h3F800000, 5'h00);
    push("p2", 32'h40000000, 5'h00);
    push("p3", 32'h40400000, 5'h00);
    ack("a1");
    ack("a2");
    ack("a3");
    idle("empty_hold");

    // Fill, overflow, and overflow beating a same-cycle CSR clear
    for (int i = 0; i < DEPTH; i++) push("fill", 32'h00000100 + 32'(i), 5'h00);
    push("ovf_drop", 32'hDEADBEEF, 5'h01);
    cycle("ovf_vs_clr", 1, 0, 32'hBADC0FFE, 5'h10, 0, 1, 10'h000);
    cycle("ovf_clr", 0, 0, 32'h0, 5'h0, 0, 1, 10'h000);

    // Push and pop together while full, then drain across the pointer wrap
    cycle("full_pa", 1, 0, 32'h00000200, 5'h02, 1, 0, 10'h0);
    for (int i = 0; i < DEPTH; i++) ack("drain");

    // Enabled-flag interrupt and clear
    cycle("mask_inx", 0, 0, 32'h0, 5'h0, 0, 1, 10'h020);
    push("inx_push", 32'h3F000000, 5'h01);
    ack("inx_ack");
    cycle("irq_clr", 0, 0, 32'h0, 5'h0, 0, 1, 10'h020);

    // CSR write merged with an accepted push
    cycle("csr_push", 1, 0, 32'h41000000, 5'h01, 0, 1, 10'h004);
    ack("csr_ack");

    // Stalled run pushes once, on release
    for (int i = 0; i < 5; i++) cycle("stall", 1, 1, 32'h42000000, 5'h08, 0, 0, 10'h0);
    cycle("release", 1, 0, 32'h42000000, 5'h08, 0, 0, 10'h0);
    idle("post_rel");
    ack("rel_ack");

    // Asynchronous reset with entries queued
    push("q1", 32'h11111111, 5'h04);
    push("q2", 32'h22222222, 5'h02);
    #2;
    rst_n = 1'b0;
    bus.fp_run = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    step();
    check_outputs("rst_edge");
    bus.fp_run = 1'b0;
    rst_n = 1'b1;
    idle("post_rst");

    // Mixed random traffic
    for (int i = 0; i < 40; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            $urandom(), 5'($urandom()), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 10'($urandom()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
